// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: ID-side decode, controller stall/flush, and the EX-side registered copies.
// The driver (master) owns the *_id_i and control inputs; the pipe register (slave) owns the *_ex_o outputs.
interface id_ex_pipe_reg_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_OP_W = 5,
    parameter int unsigned CNT_W    = 16
);
    logic                stall_ex_i;
    logic                flush_i;
    logic                valid_id_i;
    logic [XLEN-1:0]     pc_id_i;
    logic [31:0]         inst_id_i;
    logic [ALU_OP_W-1:0] alu_op_id_i;
    logic                rs1_re_id_i;
    logic [4:0]          rs1_addr_id_i;
    logic [XLEN-1:0]     rs1_data_id_i;
    logic                rs2_re_id_i;
    logic [4:0]          rs2_addr_id_i;
    logic [XLEN-1:0]     rs2_data_id_i;
    logic [XLEN-1:0]     imm_id_i;
    logic                rd_we_id_i;
    logic [4:0]          rd_addr_id_i;
    logic                mem_re_id_i;
    logic                mem_we_id_i;
    logic [2:0]          mem_size_id_i;

    logic                valid_ex_o;
    logic [XLEN-1:0]     pc_ex_o;
    logic [31:0]         inst_ex_o;
    logic [ALU_OP_W-1:0] alu_op_ex_o;
    logic [XLEN-1:0]     rs1_data_ex_o;
    logic [XLEN-1:0]     rs2_data_ex_o;
    logic [XLEN-1:0]     imm_ex_o;
    logic                rd_we_ex_o;
    logic [4:0]          rd_addr_ex_o;
    logic                mem_re_ex_o;
    logic                mem_we_ex_o;
    logic [2:0]          mem_size_ex_o;
    logic                load_use_stall_o;
    logic [CNT_W-1:0]    bubble_cnt_o;

    modport master (
        output stall_ex_i, flush_i, valid_id_i, pc_id_i, inst_id_i, alu_op_id_i,
               rs1_re_id_i, rs1_addr_id_i, rs1_data_id_i, rs2_re_id_i, rs2_addr_id_i,
               rs2_data_id_i, imm_id_i, rd_we_id_i, rd_addr_id_i, mem_re_id_i,
               mem_we_id_i, mem_size_id_i,
        input  valid_ex_o, pc_ex_o, inst_ex_o, alu_op_ex_o, rs1_data_ex_o, rs2_data_ex_o,
               imm_ex_o, rd_we_ex_o, rd_addr_ex_o, mem_re_ex_o, mem_we_ex_o,
               mem_size_ex_o, load_use_stall_o, bubble_cnt_o
    );

    modport slave (
        input  stall_ex_i, flush_i, valid_id_i, pc_id_i, inst_id_i, alu_op_id_i,
               rs1_re_id_i, rs1_addr_id_i, rs1_data_id_i, rs2_re_id_i, rs2_addr_id_i,
               rs2_data_id_i, imm_id_i, rd_we_id_i, rd_addr_id_i, mem_re_id_i,
               mem_we_id_i, mem_size_id_i,
        output valid_ex_o, pc_ex_o, inst_ex_o, alu_op_ex_o, rs1_data_ex_o, rs2_data_ex_o,
               imm_ex_o, rd_we_ex_o, rd_addr_ex_o, mem_re_ex_o, mem_we_ex_o,
               mem_size_ex_o, load_use_stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a
// saturating bubble counter. Priority per edge: flush, stall (hold), load-use, capture.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_OP_W = 5,
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic              clk,
    input logic              rst_n,
    id_ex_pipe_reg_if.slave  bus
);
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic bubble;

    // A load in EX cannot forward its data in time to an ID consumer of the same register.
    always_comb begin
        rs1_hit  = bus.rs1_re_id_i && (bus.rs1_addr_id_i == bus.rd_addr_ex_o);
        rs2_hit  = bus.rs2_re_id_i && (bus.rs2_addr_id_i == bus.rd_addr_ex_o);
        load_use = bus.valid_ex_o && bus.mem_re_ex_o && bus.rd_we_ex_o &&
                   (bus.rd_addr_ex_o != '0) && (rs1_hit || rs2_hit);
        bubble   = bus.flush_i || (!bus.stall_ex_i && load_use);
    end

    assign bus.load_use_stall_o = load_use && !bus.stall_ex_i && !bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_ex_o    <= 1'b0;
            bus.pc_ex_o       <= '0;
            bus.inst_ex_o     <= NOP_INST;
            bus.alu_op_ex_o   <= '0;
            bus.rs1_data_ex_o <= '0;
            bus.rs2_data_ex_o <= '0;
            bus.imm_ex_o      <= '0;
            bus.rd_we_ex_o    <= 1'b0;
            bus.rd_addr_ex_o  <= '0;
            bus.mem_re_ex_o   <= 1'b0;
            bus.mem_we_ex_o   <= 1'b0;
            bus.mem_size_ex_o <= '0;
        end else if (bubble) begin
            bus.valid_ex_o    <= 1'b0;
            bus.pc_ex_o       <= '0;
            bus.inst_ex_o     <= NOP_INST;
            bus.alu_op_ex_o   <= '0;
            bus.rs1_data_ex_o <= '0;
            bus.rs2_data_ex_o <= '0;
            bus.imm_ex_o      <= '0;
            bus.rd_we_ex_o    <= 1'b0;
            bus.rd_addr_ex_o  <= '0;
            bus.mem_re_ex_o   <= 1'b0;
            bus.mem_we_ex_o   <= 1'b0;
            bus.mem_size_ex_o <= '0;
        end else if (!bus.stall_ex_i) begin
            bus.valid_ex_o    <= bus.valid_id_i;
            bus.pc_ex_o       <= bus.pc_id_i;
            bus.inst_ex_o     <= bus.inst_id_i;
            bus.alu_op_ex_o   <= bus.alu_op_id_i;
            bus.rs1_data_ex_o <= bus.rs1_data_id_i;
            bus.rs2_data_ex_o <= bus.rs2_data_id_i;
            bus.imm_ex_o      <= bus.imm_id_i;
            // Architectural side effects are suppressed for an invalid ID slot.
            bus.rd_we_ex_o    <= bus.rd_we_id_i && bus.valid_id_i;
            bus.rd_addr_ex_o  <= bus.rd_addr_id_i;
            bus.mem_re_ex_o   <= bus.mem_re_id_i;
            bus.mem_we_ex_o   <= bus.mem_we_id_i && bus.valid_id_i;
            bus.mem_size_ex_o <= bus.mem_size_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bubble_cnt_o <= '0;
        end else if (bubble && (bus.bubble_cnt_o != '1)) begin
            bus.bubble_cnt_o <= bus.bubble_cnt_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomised and directed bench for id_ex_pipe_reg (CNT_W=4 build) with a behavioural
// model of the EX slot compared on every falling edge, plus literal spot checks.
module tb_id_ex_pipe_reg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.XLEN(XLEN), .ALU_OP_W(AW), .CNT_W(CW)) bus ();

    id_ex_pipe_reg #(.XLEN(XLEN), .ALU_OP_W(AW), .CNT_W(CW), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  alu;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        rd_we;
        logic [4:0]  rd;
        logic        mre;
        logic        mwe;
        logic [2:0]  msz;
    } ex_t;

    ex_t exp_ex;
    int  exp_cnt;

    function automatic ex_t empty_slot();
        ex_t e;
        e = '{valid: 1'b0, pc: '0, inst: NOP, alu: '0, rs1: '0, rs2: '0, imm: '0,
              rd_we: 1'b0, rd: '0, mre: 1'b0, mwe: 1'b0, msz: '0};
        return e;
    endfunction

    // The EX instruction is a real load writing a nonzero register that ID reads.
    function automatic bit model_hazard();
        bit reads;
        reads = (bus.rs1_re_id_i && bus.rs1_addr_id_i == exp_ex.rd) ||
                (bus.rs2_re_id_i && bus.rs2_addr_id_i == exp_ex.rd);
        return exp_ex.valid && exp_ex.mre && exp_ex.rd_we && exp_ex.rd != 0 && reads;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ex  = empty_slot();
            exp_cnt = 0;
        end else if (bus.flush_i || (!bus.stall_ex_i && model_hazard())) begin
            exp_ex  = empty_slot();
            exp_cnt = (exp_cnt + 1 > CMAX) ? CMAX : exp_cnt + 1;
        end else if (!bus.stall_ex_i) begin
            exp_ex.valid = bus.valid_id_i;
            exp_ex.pc    = bus.pc_id_i;
            exp_ex.inst  = bus.inst_id_i;
            exp_ex.alu   = bus.alu_op_id_i;
            exp_ex.rs1   = bus.rs1_data_id_i;
            exp_ex.rs2   = bus.rs2_data_id_i;
            exp_ex.imm   = bus.imm_id_i;
            exp_ex.rd_we = bus.valid_id_i ? bus.rd_we_id_i : 1'b0;
            exp_ex.rd    = bus.rd_addr_id_i;
            exp_ex.mre   = bus.mem_re_id_i;
            exp_ex.mwe   = bus.valid_id_i ? bus.mem_we_id_i : 1'b0;
            exp_ex.msz   = bus.mem_size_id_i;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n === 1'b1) begin
            chk("valid_ex", 64'(bus.valid_ex_o), 64'(exp_ex.valid));
            chk("pc_ex", 64'(bus.pc_ex_o), 64'(exp_ex.pc));
            chk("inst_ex", 64'(bus.inst_ex_o), 64'(exp_ex.inst));
            chk("alu_op_ex", 64'(bus.alu_op_ex_o), 64'(exp_ex.alu));
            chk("rs_data_ex", {bus.rs1_data_ex_o, bus.rs2_data_ex_o}, {exp_ex.rs1, exp_ex.rs2});
            chk("imm_ex", 64'(bus.imm_ex_o), 64'(exp_ex.imm));
            chk("ctl_ex", 64'({bus.rd_we_ex_o, bus.rd_addr_ex_o, bus.mem_re_ex_o, bus.mem_we_ex_o,
                               bus.mem_size_ex_o}),
                64'({exp_ex.rd_we, exp_ex.rd, exp_ex.mre, exp_ex.mwe, exp_ex.msz}));
            chk("load_use_stall", 64'(bus.load_use_stall_o),
                64'(model_hazard() && !bus.stall_ex_i && !bus.flush_i));
            chk("bubble_cnt", 64'(bus.bubble_cnt_o), 64'(exp_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [31:0] pc, input logic mre, input logic rdwe,
                           input logic [4:0] rd, input logic r1re, input logic [4:0] r1,
                           input logic r2re, input logic [4:0] r2);
        bus.valid_id_i    = v;
        bus.pc_id_i       = pc;
        bus.inst_id_i     = $urandom;
        bus.alu_op_id_i   = 5'($urandom);
        bus.rs1_re_id_i   = r1re;
        bus.rs1_addr_id_i = r1;
        bus.rs1_data_id_i = $urandom;
        bus.rs2_re_id_i   = r2re;
        bus.rs2_addr_id_i = r2;
        bus.rs2_data_id_i = $urandom;
        bus.imm_id_i      = $urandom;
        bus.rd_we_id_i    = rdwe;
        bus.rd_addr_id_i  = rd;
        bus.mem_re_id_i   = mre;
        bus.mem_we_id_i   = 1'b0;
        bus.mem_size_id_i = 3'($urandom);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.stall_ex_i = 1'b0;
        bus.flush_i    = 1'b0;
        set_ins(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        #12;
        chk("reset_valid", 64'(bus.valid_ex_o), 64'd0);
        chk("reset_inst", 64'(bus.inst_ex_o), 64'h13);
        chk("reset_cnt", 64'(bus.bubble_cnt_o), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            set_ins(1'b1, 32'(i * 4), 1'b0, 1'b1, 5'(i + 1), 1'b1, 5'(i + 10), 1'b1, 5'(i + 20));
            tick();
            chk("flow_pc", 64'(bus.pc_ex_o), 64'(i * 4));
        end

        // lw x5 then add x6,x5,x7
        set_ins(1'b1, 32'h10, 1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0);
        tick();
        set_ins(1'b1, 32'h14, 1'b0, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7);
        #1 chk("lu_stall_hi", 64'(bus.load_use_stall_o), 64'd1);
        tick();
        chk("lu_bubble_valid", 64'(bus.valid_ex_o), 64'd0);
        chk("lu_bubble_inst", 64'(bus.inst_ex_o), 64'h13);
        chk("lu_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd1);
        chk("lu_stall_lo", 64'(bus.load_use_stall_o), 64'd0);
        tick();
        chk("lu_add_pc", 64'(bus.pc_ex_o), 64'h14);
        chk("lu_add_valid", 64'(bus.valid_ex_o), 64'd1);

        // lw x0 -> add x6,x0,x7
        set_ins(1'b1, 32'h18, 1'b1, 1'b1, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0);
        tick();
        set_ins(1'b1, 32'h1C, 1'b0, 1'b1, 5'd6, 1'b1, 5'd0, 1'b1, 5'd7);
        #1 chk("x0_no_stall", 64'(bus.load_use_stall_o), 64'd0);
        tick();

        // lw x5 -> rs2 index matches but rs2 is not read
        set_ins(1'b1, 32'h20, 1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b0, 5'd0);
        tick();
        set_ins(1'b1, 32'h24, 1'b0, 1'b1, 5'd6, 1'b1, 5'd7, 1'b0, 5'd5);
        #1 chk("rs2re_no_stall", 64'(bus.load_use_stall_o), 64'd0);
        tick();

        // Flush beats stall beats load-use
        set_ins(1'b1, 32'h28, 1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0);
        tick();
        set_ins(1'b1, 32'h2C, 1'b0, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7);
        bus.stall_ex_i = 1'b1;
        bus.flush_i    = 1'b1;
        #1 chk("prio_stall_out", 64'(bus.load_use_stall_o), 64'd0);
        tick();
        chk("prio_valid", 64'(bus.valid_ex_o), 64'd0);
        chk("prio_cnt", 64'(bus.bubble_cnt_o), 64'd2);
        bus.stall_ex_i = 1'b0;
        bus.flush_i    = 1'b0;

        // Stall freeze
        set_ins(1'b1, 32'h40, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        bus.stall_ex_i = 1'b1;
        set_ins(1'b1, 32'h44, 1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) tick();
        chk("stall_pc", 64'(bus.pc_ex_o), 64'h40);
        chk("stall_rd", 64'(bus.rd_addr_ex_o), 64'd9);
        chk("stall_cnt", 64'(bus.bubble_cnt_o), 64'd2);
        bus.stall_ex_i = 1'b0;
        tick();
        chk("unstall_pc", 64'(bus.pc_ex_o), 64'h44);

        // Asynchronous reset mid-cycle
        #1 rst_n = 1'b0;
        #1;
        chk("areset_valid", 64'(bus.valid_ex_o), 64'd0);
        chk("areset_pc", 64'(bus.pc_ex_o), 64'd0);
        chk("areset_inst", 64'(bus.inst_ex_o), 64'h13);
        chk("areset_cnt", 64'(bus.bubble_cnt_o), 64'd0);
        #1 rst_n = 1'b1;
        tick();

        // Counter saturation
        bus.flush_i = 1'b1;
        repeat (14) tick();
        chk("sat_cnt14", 64'(bus.bubble_cnt_o), 64'hE);
        repeat (2) tick();
        chk("sat_cnt16", 64'(bus.bubble_cnt_o), 64'hF);
        repeat (4) tick();
        chk("sat_cnt20", 64'(bus.bubble_cnt_o), 64'hF);
        bus.flush_i = 1'b0;

        // Randomised traffic with small register indices to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            bus.stall_ex_i = ($urandom_range(0, 7) == 0);
            bus.flush_i    = ($urandom_range(0, 15) == 0);
            set_ins(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                    1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
            bus.mem_we_id_i = 1'($urandom);
            if (i == 1000) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
